// File: rtl/blinker_multi.sv
// blinker_multi: shared-prescaler multi-channel LED driver.
// Per-channel off / on / lockstep blink / retriggerable one-shot.
module blinker_multi #(
   parameter int CHANNELS       = 4,
   parameter int CNT_W          = 24,
   parameter int DEFAULT_PERIOD = 1000,
   parameter int PULSE_TICKS    = 3,
   parameter int PULSE_W        = 4
) (
   input  logic                  system1000,
   input  logic                  system1000_rst,
   input  logic                  cfg_we,
   input  logic [CNT_W-1:0]      cfg_period,
   input  logic [2*CHANNELS-1:0] mode,
   input  logic [CHANNELS-1:0]   trig,
   output logic [CHANNELS-1:0]   led,
   output logic                  tick
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_SHOT  = 2'b11
   } mode_e;

   logic [CNT_W-1:0]   period_q;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   p_eff;
   logic               phase;
   logic               phase_d;
   logic               wrap;
   logic [CHANNELS-1:0] trig_q;
   logic [CHANNELS-1:0] led_d;
   logic [PULSE_W-1:0] shot_q [CHANNELS];
   logic [PULSE_W-1:0] shot_d [CHANNELS];

   // A zero period runs as period 1; a config write swallows the wrap.
   always_comb begin
      p_eff   = (period_q == '0) ? CNT_W'(1) : period_q;
      wrap    = !cfg_we && (cnt == p_eff - CNT_W'(1));
      phase_d = phase ^ wrap;
   end

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         shot_d[i] = '0;
         led_d[i]  = 1'b0;
         unique case (mode_e'(mode[2*i +: 2]))
            MODE_OFF:   led_d[i] = 1'b0;
            MODE_ON:    led_d[i] = 1'b1;
            MODE_BLINK: led_d[i] = phase_d;
            MODE_SHOT: begin
               if (trig[i] && !trig_q[i])
                  shot_d[i] = PULSE_W'(PULSE_TICKS);
               else if (wrap && shot_q[i] != '0)
                  shot_d[i] = shot_q[i] - PULSE_W'(1);
               else
                  shot_d[i] = shot_q[i];
               led_d[i] = (shot_d[i] != '0);
            end
            default: led_d[i] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge system1000 or posedge system1000_rst) begin
      if (system1000_rst) begin
         period_q <= CNT_W'(DEFAULT_PERIOD);
         cnt      <= '0;
         tick     <= 1'b0;
         phase    <= 1'b0;
         trig_q   <= '0;
         led      <= '0;
         shot_q   <= '{default: '0};
      end else begin
         trig_q <= trig;
         phase  <= phase_d;
         led    <= led_d;
         shot_q <= shot_d;
         if (cfg_we) begin
            period_q <= cfg_period;
            cnt      <= '0;
            tick     <= 1'b0;
         end else if (wrap) begin
            cnt  <= '0;
            tick <= 1'b1;
         end else begin
            cnt  <= cnt + CNT_W'(1);
            tick <= 1'b0;
         end
      end
   end

endmodule
